// File: rtl/linear_sensor_ctrl.sv
// Line-scan sensor controller: fetches T/N from config RAM, then loops integrate / readout / blank.
// Latency: start edge -> INTEG in 3 cycles; pixel k appears 2+k cycles after ad_sp is sampled.
// Backpressure: none; the pixel stream is free-running and the pixel buffer must take every strobe.
module linear_sensor_ctrl #(
   parameter int unsigned PIX_NUM    = 512,
   parameter int unsigned ADC_W      = 16,
   parameter int unsigned BLANK_CYC  = 24,
   parameter int unsigned DONE_CYC   = 33,
   parameter int unsigned SP_TIMEOUT = 4096,
   parameter logic [7:0]  INTEG_ADDR = 8'd1,
   parameter logic [7:0]  CAP_ADDR   = 8'd2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_in,
   input  logic                       soft_reset_in,
   output logic                       cfg_ram_rd_o,
   output logic [7:0]                 cfg_ram_addr_o,
   input  logic [31:0]                cfg_ram_din,
   output logic                       sensor_clk_o,
   output logic                       sensor_reset_o,
   input  logic                       ad_sp,
   input  logic [ADC_W-1:0]           ad_data,
   output logic                       pix_valid_o,
   output logic [ADC_W-1:0]           pix_data_o,
   output logic [$clog2(PIX_NUM)-1:0] pix_idx_o,
   output logic                       line_last_o,
   output logic [31:0]                line_cnt_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       timeout_o
);

   localparam int unsigned IDX_W = $clog2(PIX_NUM);

   // Terminal values of the shared cycle counter for the fixed-length states.
   localparam logic [31:0] PIX_LAST   = 32'(PIX_NUM - 1);
   localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYC - 1);
   localparam logic [31:0] DONE_LAST  = 32'(DONE_CYC - 1);
   localparam logic [31:0] TO_LAST    = 32'(SP_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, RD_INTEG, RD_CAP, INTEG, WAIT_SP, DATA, BLANK, DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        cnt_q, cnt_d;
   logic               start_r_q;
   logic [31:0]        integ_q, integ_d;
   logic [31:0]        cap_q, cap_d;
   logic [31:0]        line_cnt_q, line_cnt_d;
   logic               pix_valid_q, pix_valid_d;
   logic [ADC_W-1:0]   pix_data_q, pix_data_d;
   logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
   logic               line_last_q, line_last_d;
   logic               timeout_q, timeout_d;
   logic               cfg_rd_q, cfg_rd_d;
   logic [7:0]         cfg_addr_q, cfg_addr_d;
   logic               start_edge;
   logic               abort;
   logic               capture;

   // Next state, counter, config latches, pixel capture and pulse generation.
   always_comb begin
      state_d     = state_q;
      integ_d     = integ_q;
      cap_d       = cap_q;
      line_cnt_d  = line_cnt_q;
      pix_valid_d = 1'b0;
      pix_data_d  = pix_data_q;
      pix_idx_d   = pix_idx_q;
      line_last_d = 1'b0;
      timeout_d   = 1'b0;
      start_edge  = start_in & ~start_r_q;
      abort       = soft_reset_in && (state_q != IDLE);
      capture     = (state_q == DATA) && !soft_reset_in;

      unique case (state_q)
         IDLE:     if (start_edge) state_d = RD_INTEG;
         RD_INTEG: state_d = RD_CAP;
         RD_CAP:   state_d = INTEG;
         INTEG:    if (cnt_q == integ_q - 32'd1) state_d = WAIT_SP;
         WAIT_SP: begin
            if (ad_sp) begin
               state_d = DATA;
            end else if (cnt_q == TO_LAST) begin
               state_d   = IDLE;
               timeout_d = !soft_reset_in;
            end
         end
         DATA:     if (cnt_q == PIX_LAST) state_d = BLANK;
         BLANK: begin
            if (cnt_q == BLANK_LAST) state_d = (line_cnt_q == cap_q) ? DONE : INTEG;
         end
         DONE:     if (cnt_q == DONE_LAST) state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      // Abort wins over every other transition, including terminal counts and ad_sp.
      if (abort) state_d = IDLE;

      // A zero configuration word means "one".
      if (state_q == RD_INTEG) integ_d = (cfg_ram_din == 32'd0) ? 32'd1 : cfg_ram_din;
      if (state_q == RD_CAP)   cap_d   = (cfg_ram_din == 32'd0) ? 32'd1 : cfg_ram_din;

      if (state_q == IDLE && state_d == RD_INTEG)      line_cnt_d = 32'd0;
      else if (state_q == DATA && state_d == BLANK)    line_cnt_d = line_cnt_q + 32'd1;

      // Cycle counter restarts on every state change.
      cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;

      // The aborting cycle is not captured, so a partial line never flags its last pixel.
      if (capture) begin
         pix_valid_d = 1'b1;
         pix_data_d  = ad_data;
         pix_idx_d   = cnt_q[IDX_W-1:0];
         line_last_d = (cnt_q == PIX_LAST);
      end

      // Config RAM strobes follow the state register; registered from state_d so they are 0 in reset.
      cfg_rd_d   = (state_d == IDLE) || (state_d == RD_INTEG);
      cfg_addr_d = (state_d == IDLE)     ? INTEG_ADDR :
                   (state_d == RD_INTEG) ? CAP_ADDR   : 8'd0;
   end

   // FSM state, cycle counter and start-edge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 32'd0;
         start_r_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         start_r_q <= start_in;
      end
   end

   // Datapath registers: config latches, line counter, pixel stream, pulses, RAM strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         integ_q     <= 32'd1;
         cap_q       <= 32'd1;
         line_cnt_q  <= 32'd0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
         pix_idx_q   <= '0;
         line_last_q <= 1'b0;
         timeout_q   <= 1'b0;
         cfg_rd_q    <= 1'b0;
         cfg_addr_q  <= 8'd0;
      end else begin
         integ_q     <= integ_d;
         cap_q       <= cap_d;
         line_cnt_q  <= line_cnt_d;
         pix_valid_q <= pix_valid_d;
         pix_data_q  <= pix_data_d;
         pix_idx_q   <= pix_idx_d;
         line_last_q <= line_last_d;
         timeout_q   <= timeout_d;
         cfg_rd_q    <= cfg_rd_d;
         cfg_addr_q  <= cfg_addr_d;
      end
   end

   assign sensor_clk_o   = ~clk;
   assign sensor_reset_o = (state_q == INTEG);
   assign busy_o         = (state_q != IDLE);
   assign done_o         = (state_q == DONE);
   assign cfg_ram_rd_o   = cfg_rd_q;
   assign cfg_ram_addr_o = cfg_addr_q;
   assign pix_valid_o    = pix_valid_q;
   assign pix_data_o     = pix_data_q;
   assign pix_idx_o      = pix_idx_q;
   assign line_last_o    = line_last_q;
   assign line_cnt_o     = line_cnt_q;
   assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_linear_sensor_ctrl.sv
// Bench for linear_sensor_ctrl: small pixel count, short timeout, config RAM model and ramp ADC.
// Latency: expected cycle numbers are derived from the start cycle and the ad_sp cycle.
// Backpressure: none; a negedge monitor tallies every output strobe.
module tb_linear_sensor_ctrl;

   localparam int PIX  = 8;
   localparam int BLK  = 24;
   localparam int DCYC = 33;
   localparam int SPTO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start_in = 1'b1;
   logic        soft_reset_in = 1'b0;
   logic        ad_sp = 1'b0;
   logic [15:0] ad_data;
   logic [31:0] cfg_ram_din = 32'd0;
   logic        cfg_ram_rd_o;
   logic [7:0]  cfg_ram_addr_o;
   logic        sensor_clk_o, sensor_reset_o;
   logic        pix_valid_o, line_last_o, busy_o, done_o, timeout_o;
   logic [15:0] pix_data_o;
   logic [2:0]  pix_idx_o;
   logic [31:0] line_cnt_o;

   logic [31:0] cfg_mem [256];
   int cyc = 0;
   int passed = 0;
   int total = 0;

   // Monitor tallies
   int sr_cnt, sr_first, pix_cnt, pix_first, pix_err, exp_idx, last_cnt;
   int done_cnt, done_win, done_first, to_cnt, to_cyc, busy_cnt, busy_last;
   int lc_steps, lc_err;
   logic done_prev;
   logic [31:0] lc_prev;

   typedef struct {
      int t; int n; int d; int mid_start;
      int exp_sr; int exp_pix; int exp_lines;
   } vec_t;
   vec_t vecs[4];

   linear_sensor_ctrl #(
      .PIX_NUM(PIX), .ADC_W(16), .BLANK_CYC(BLK), .DONE_CYC(DCYC),
      .SP_TIMEOUT(SPTO), .INTEG_ADDR(8'd1), .CAP_ADDR(8'd2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_in(start_in), .soft_reset_in(soft_reset_in),
      .cfg_ram_rd_o(cfg_ram_rd_o), .cfg_ram_addr_o(cfg_ram_addr_o), .cfg_ram_din(cfg_ram_din),
      .sensor_clk_o(sensor_clk_o), .sensor_reset_o(sensor_reset_o),
      .ad_sp(ad_sp), .ad_data(ad_data),
      .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o), .pix_idx_o(pix_idx_o),
      .line_last_o(line_last_o), .line_cnt_o(line_cnt_o), .busy_o(busy_o),
      .done_o(done_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Config RAM: data valid one cycle after the address.
   always @(posedge clk) cfg_ram_din <= cfg_mem[cfg_ram_addr_o];

   function automatic logic [15:0] ramp(input int n);
      return 16'(n * 37 + 32'h1200);
   endfunction

   // ADC ramp: during cycle n the sample is ramp(n).
   initial ad_data = ramp(0);
   always @(posedge clk) begin
      #1;
      ad_data = ramp(cyc);
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic mon_clear();
      sr_cnt = 0; sr_first = -1; pix_cnt = 0; pix_first = -1; pix_err = 0; exp_idx = 0;
      last_cnt = 0; done_cnt = 0; done_win = 0; done_first = -1; to_cnt = 0; to_cyc = -1;
      busy_cnt = 0; busy_last = -1; lc_steps = 0; lc_err = 0;
      done_prev = done_o; lc_prev = line_cnt_o;
   endtask

   always @(negedge clk) begin
      if (sensor_reset_o) begin
         if (sr_cnt == 0) sr_first = cyc;
         sr_cnt++;
      end
      if (pix_valid_o) begin
         if (pix_cnt == 0) pix_first = cyc;
         pix_cnt++;
         if (pix_data_o != ramp(cyc - 1)) pix_err++;
         if (int'(pix_idx_o) != exp_idx) pix_err++;
         if (line_last_o != (exp_idx == PIX - 1)) pix_err++;
         exp_idx = (exp_idx == PIX - 1) ? 0 : exp_idx + 1;
      end else if (line_last_o) begin
         pix_err++;
      end
      if (line_last_o) last_cnt++;
      if (done_o) begin
         if (!done_prev) begin
            done_win++;
            if (done_first < 0) done_first = cyc;
         end
         done_cnt++;
      end
      done_prev = done_o;
      if (timeout_o) begin
         to_cnt++;
         to_cyc = cyc;
      end
      if (busy_o) begin
         busy_cnt++;
         busy_last = cyc;
      end
      if (line_cnt_o == lc_prev + 32'd1) lc_steps++;
      else if (line_cnt_o != lc_prev && line_cnt_o != 32'd0) lc_err++;
      lc_prev = line_cnt_o;
   end

   task automatic start_run(output int c);
      mon_clear();
      start_in = 1'b1;
      c = cyc;
      wait_cyc(c + 1);
      start_in = 1'b0;
   endtask

   // Runs a complete scan; returns start cycle, first ad_sp cycle and first IDLE cycle.
   task automatic run_normal(input int t, input int n, input int d, input int mid,
                             output int c, output int w0, output int idle_cyc);
      int teff;
      int integ;
      int w;
      teff = (t == 0) ? 1 : t;
      cfg_mem[1] = t;
      cfg_mem[2] = n;
      start_run(c);
      integ = c + 3;
      w0 = integ + teff + d;
      if (mid != 0) begin
         wait_cyc(c + mid);
         start_in = 1'b1;
         wait_cyc(c + mid + 1);
         start_in = 1'b0;
      end
      for (int l = 0; l < n; l++) begin
         w = integ + teff + d;
         wait_cyc(w);
         ad_sp = 1'b1;
         wait_cyc(w + 1);
         ad_sp = 1'b0;
         integ = w + PIX + BLK + 1;
      end
      idle_cyc = integ + DCYC;
      wait_cyc(idle_cyc + 2);
   endtask

   initial begin
      int c, w0, w1, idle_c;

      for (int i = 0; i < 256; i++) cfg_mem[i] = 32'(i * 1000 + 17);

      vecs[0] = '{t: 5, n: 1, d: 3, mid_start: 0, exp_sr: 5,  exp_pix: 8,  exp_lines: 1};
      vecs[1] = '{t: 0, n: 3, d: 0, mid_start: 0, exp_sr: 3,  exp_pix: 24, exp_lines: 3};
      vecs[2] = '{t: 2, n: 2, d: 1, mid_start: 0, exp_sr: 4,  exp_pix: 16, exp_lines: 2};
      vecs[3] = '{t: 5, n: 1, d: 3, mid_start: 6, exp_sr: 5,  exp_pix: 8,  exp_lines: 1};

      // Reset with start_in held high throughout.
      #1 rst_n = 1'b0;
      wait_cyc(2);
      @(negedge clk);
      chk("rst_cfg_rd", cfg_ram_rd_o, 0);
      chk("rst_cfg_addr", cfg_ram_addr_o, 0);
      chk("rst_sensor_reset", sensor_reset_o, 0);
      chk("rst_pix_valid", pix_valid_o, 0);
      chk("rst_pix_data", pix_data_o, 0);
      chk("rst_pix_idx", pix_idx_o, 0);
      chk("rst_line_last", line_last_o, 0);
      chk("rst_line_cnt", line_cnt_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_timeout", timeout_o, 0);
      chk("sensor_clk_inv", sensor_clk_o, 1);
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(4);
      @(negedge clk);
      chk("idle_cfg_rd", cfg_ram_rd_o, 1);
      chk("idle_cfg_addr", cfg_ram_addr_o, 1);
      wait_cyc(5);
      mon_clear();
      wait_cyc(25);
      chk("held_start_busy", busy_cnt, 0);
      start_in = 1'b0;
      wait_cyc(27);

      // Table-driven full scans.
      for (int i = 0; i < 4; i++) begin
         run_normal(vecs[i].t, vecs[i].n, vecs[i].d, vecs[i].mid_start, c, w0, idle_c);
         chk($sformatf("v%0d_sr_cycles", i), sr_cnt, vecs[i].exp_sr);
         chk($sformatf("v%0d_sr_first", i), sr_first, c + 3);
         chk($sformatf("v%0d_pix_count", i), pix_cnt, vecs[i].exp_pix);
         chk($sformatf("v%0d_pix_first", i), pix_first, w0 + 2);
         chk($sformatf("v%0d_pix_errs", i), pix_err, 0);
         chk($sformatf("v%0d_line_last", i), last_cnt, vecs[i].exp_lines);
         chk($sformatf("v%0d_done_cycles", i), done_cnt, DCYC);
         chk($sformatf("v%0d_done_windows", i), done_win, 1);
         chk($sformatf("v%0d_done_first", i), done_first, idle_c - DCYC);
         chk($sformatf("v%0d_timeout", i), to_cnt, 0);
         chk($sformatf("v%0d_line_cnt", i), line_cnt_o, vecs[i].exp_lines);
         chk($sformatf("v%0d_line_steps", i), lc_steps, vecs[i].exp_lines);
         chk($sformatf("v%0d_line_cnt_err", i), lc_err, 0);
         chk($sformatf("v%0d_busy_last", i), busy_last, idle_c - 1);
      end

      // ad_sp never arrives: timeout 16 cycles into WAIT_SP (WAIT_SP starts at c+8).
      cfg_mem[1] = 5;
      cfg_mem[2] = 1;
      start_run(c);
      wait_cyc(c + 8 + SPTO + 4);
      chk("to_pulses", to_cnt, 1);
      chk("to_cycle", to_cyc, c + 8 + SPTO);
      chk("to_busy_last", busy_last, c + 8 + SPTO - 1);
      chk("to_done", done_cnt, 0);
      chk("to_pix", pix_cnt, 0);
      chk("to_sr", sr_cnt, 5);

      // Soft reset during pixel 4 of line 2, N=3, T=2.
      cfg_mem[1] = 2;
      cfg_mem[2] = 3;
      start_run(c);
      w0 = c + 5;
      wait_cyc(w0);
      ad_sp = 1'b1;
      wait_cyc(w0 + 1);
      ad_sp = 1'b0;
      w1 = w0 + PIX + BLK + 1 + 2;
      wait_cyc(w1);
      ad_sp = 1'b1;
      wait_cyc(w1 + 1);
      ad_sp = 1'b0;
      wait_cyc(w1 + 5);
      soft_reset_in = 1'b1;
      wait_cyc(w1 + 6);
      soft_reset_in = 1'b0;
      wait_cyc(w1 + 12);
      chk("sr_abort_pix", pix_cnt, PIX + 4);
      chk("sr_abort_last", last_cnt, 1);
      chk("sr_abort_line_cnt", line_cnt_o, 1);
      chk("sr_abort_done", done_cnt, 0);
      chk("sr_abort_timeout", to_cnt, 0);
      chk("sr_abort_busy_last", busy_last, w1 + 5);
      chk("sr_abort_pix_errs", pix_err, 0);

      // A fresh start after the abort runs normally.
      run_normal(5, 1, 3, 0, c, w0, idle_c);
      chk("rerun_pix", pix_cnt, PIX);
      chk("rerun_pix_first", pix_first, w0 + 2);
      chk("rerun_done_windows", done_win, 1);
      chk("rerun_line_cnt", line_cnt_o, 1);
      chk("rerun_pix_errs", pix_err, 0);

      // ad_sp and soft reset in the same WAIT_SP cycle (T=1, WAIT_SP starts at c+4).
      cfg_mem[1] = 1;
      cfg_mem[2] = 1;
      start_run(c);
      wait_cyc(c + 4);
      ad_sp = 1'b1;
      soft_reset_in = 1'b1;
      wait_cyc(c + 5);
      ad_sp = 1'b0;
      soft_reset_in = 1'b0;
      wait_cyc(c + 12);
      chk("sim_pix", pix_cnt, 0);
      chk("sim_busy_last", busy_last, c + 4);
      chk("sim_done", done_cnt, 0);
      chk("sim_timeout", to_cnt, 0);
      chk("sim_sr", sr_cnt, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
